btn_event_arbiter: RTL and testbench

Multi-button front end for the board's push-buttons. It synchronises N active-low asynchronous button inputs and debounces them with one shared slow tick. It detects press and long-press events and queues them as pending flags. A round-robin arbiter serialises these events to a single consumer over a valid/ready handshake, and the FSM top level reads button commands through this block.

---
 rtl/btn_event_arbiter_pkg.sv | 9 +
 rtl/btn_event_arbiter_if.sv | 9 +
 rtl/btn_debounce_chan.sv | 65 ++++++
 rtl/btn_event_arbiter.sv | 94 +++++++++
 tb/tb_btn_event_arbiter.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/btn_event_arbiter_pkg.sv
// btn_pkg: shared enums and default parameters for the push-button event front end.
package btn_pkg;
   typedef enum logic {ARB_IDLE, ARB_OFFER} arb_state_t;
   typedef enum logic {EV_PRESS = 1'b0, EV_LONG = 1'b1} ev_kind_t;
   localparam int N_BTN_DEF      = 4;
   localparam int TICK_DIV_DEF   = 250000;
   localparam int DEB_TICKS_DEF  = 4;
   localparam int LONG_TICKS_DEF = 200;
endpackage

// File: rtl/btn_event_arbiter_if.sv
// btn_event_arbiter_if: valid/ready event channel from the button front end to its consumer.
interface btn_event_arbiter_if import btn_pkg::*; #(parameter int N_BTN = N_BTN_DEF);
   logic                     valid;
   logic                     ready;
   logic [$clog2(N_BTN)-1:0] id;
   logic                     long;
   modport master (output valid, id, long, input ready);
   modport slave  (input valid, id, long, output ready);
endinterface

// File: rtl/btn_debounce_chan.sv
// btn_debounce_chan: per-button synchroniser, tick-based debouncer and long-press detector.
module btn_debounce_chan import btn_pkg::*; #(
   parameter int DEB_TICKS  = DEB_TICKS_DEF,
   parameter int LONG_TICKS = LONG_TICKS_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic btn_n_i,
   output logic level,
   output logic press_stb,
   output logic long_stb
);
   localparam int DW = $clog2(DEB_TICKS);
   localparam int HW = $clog2(LONG_TICKS);
   localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_TICKS - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 2);
   logic          sync1_q, sync2_q, sample;
   logic          level_q, level_d, long_done_q, long_done_d;
   logic [DW-1:0] deb_cnt_q, deb_cnt_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   assign sample    = ~sync2_q;
   assign level     = level_q;
   assign press_stb = level_d & ~level_q;
   always_comb begin
      level_d     = level_q;
      deb_cnt_d   = deb_cnt_q;
      hold_cnt_d  = hold_cnt_q;
      long_done_d = long_done_q;
      long_stb    = 1'b0;
      if (tick) begin
         if (sample == level_q) deb_cnt_d = '0;
         else if (deb_cnt_q == DEB_MAX) begin
            level_d   = sample;
            deb_cnt_d = '0;
         end else deb_cnt_d = deb_cnt_q + 1'b1;
         // counter stops at LONG_TICKS-1 once long_done is set, so it cannot wrap
         if (!level_q) begin
            hold_cnt_d  = '0;
            long_done_d = 1'b0;
         end else if (!long_done_q) begin
            hold_cnt_d  = hold_cnt_q + 1'b1;
            long_stb    = hold_cnt_q == HOLD_LAST;
            long_done_d = long_stb;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         level_q     <= 1'b0;
         deb_cnt_q   <= '0;
         hold_cnt_q  <= '0;
         long_done_q <= 1'b0;
      end else begin
         sync1_q     <= btn_n_i;
         sync2_q     <= sync1_q;
         level_q     <= level_d;
         deb_cnt_q   <= deb_cnt_d;
         hold_cnt_q  <= hold_cnt_d;
         long_done_q <= long_done_d;
      end
   end
endmodule

// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: debounces N buttons, queues press/long events, serves them round-robin.
module btn_event_arbiter import btn_pkg::*; #(
   parameter int N_BTN      = N_BTN_DEF,
   parameter int TICK_DIV   = TICK_DIV_DEF,
   parameter int DEB_TICKS  = DEB_TICKS_DEF,
   parameter int LONG_TICKS = LONG_TICKS_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_BTN-1:0]     btn_n,
   output logic [N_BTN-1:0]     btn_level,
   btn_event_arbiter_if.master  ev,
   output logic                 ev_overrun
);
   localparam int CW = $clog2(TICK_DIV);
   localparam int IW = $clog2(N_BTN);
   localparam logic [CW-1:0] TICK_MAX = CW'(TICK_DIV - 1);
   localparam logic [IW-1:0] ID_MAX   = IW'(N_BTN - 1);
   logic [CW-1:0]    tick_cnt_q, tick_cnt_d;
   logic             tick;
   logic [N_BTN-1:0] press_stb, long_stb, any_pend, clr;
   logic [N_BTN-1:0] press_pend_q, press_pend_d, long_pend_q, long_pend_d;
   logic             ev_overrun_q, ev_overrun_d;
   arb_state_t       state_q, state_d;
   ev_kind_t         ev_long_q, ev_long_d;
   logic [IW-1:0]    ev_id_q, ev_id_d, ptr_q, ptr_d, sel;
   assign tick       = tick_cnt_q == TICK_MAX;
   assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
   for (genvar i = 0; i < N_BTN; i++) begin : g_chan
      btn_debounce_chan #(.DEB_TICKS(DEB_TICKS), .LONG_TICKS(LONG_TICKS)) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .tick      (tick),
         .btn_n_i   (btn_n[i]),
         .level     (btn_level[i]),
         .press_stb (press_stb[i]),
         .long_stb  (long_stb[i])
      );
   end
   assign any_pend   = press_pend_q | long_pend_q;
   assign ev.valid   = state_q == ARB_OFFER;
   assign ev.id      = ev_id_q;
   assign ev.long    = ev_long_q;
   assign ev_overrun = ev_overrun_q;
   // descending scan so the closest pending button at or after ptr wins
   always_comb begin
      sel = ptr_q;
      for (int k = N_BTN - 1; k >= 0; k--)
         if (any_pend[(int'(ptr_q) + k) % N_BTN]) sel = IW'((int'(ptr_q) + k) % N_BTN);
   end
   always_comb begin
      state_d   = state_q;
      ev_id_d   = ev_id_q;
      ev_long_d = ev_long_q;
      ptr_d     = ptr_q;
      clr       = '0;
      if (state_q == ARB_IDLE) begin
         if (|any_pend) begin
            ev_id_d   = sel;
            ev_long_d = press_pend_q[sel] ? EV_PRESS : EV_LONG;
            state_d   = ARB_OFFER;
         end
      end else if (ev.ready) begin
         clr[ev_id_q] = 1'b1;
         ptr_d        = ev_id_q == ID_MAX ? '0 : ev_id_q + 1'b1;
         state_d      = ARB_IDLE;
      end
      // a strobe in the same cycle as the accept re-sets the bit, so it is offered again
      press_pend_d = (press_pend_q & ~(ev_long_q == EV_PRESS ? clr : '0)) | press_stb;
      long_pend_d  = (long_pend_q & ~(ev_long_q == EV_LONG ? clr : '0)) | long_stb;
      ev_overrun_d = ev_overrun_q | |(press_stb & press_pend_q) | |(long_stb & long_pend_q);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt_q   <= '0;
         press_pend_q <= '0;
         long_pend_q  <= '0;
         ev_overrun_q <= 1'b0;
         state_q      <= ARB_IDLE;
         ev_id_q      <= '0;
         ev_long_q    <= EV_PRESS;
         ptr_q        <= '0;
      end else begin
         tick_cnt_q   <= tick_cnt_d;
         press_pend_q <= press_pend_d;
         long_pend_q  <= long_pend_d;
         ev_overrun_q <= ev_overrun_d;
         state_q      <= state_d;
         ev_id_q      <= ev_id_d;
         ev_long_q    <= ev_long_d;
         ptr_q        <= ptr_d;
      end
   end
endmodule

// File: tb/tb_btn_event_arbiter.sv
// tb_btn_event_arbiter: scoreboard bench for btn_event_arbiter with small tick/debounce constants.
module tb_btn_event_arbiter;
   localparam int N_BTN = 4;
   typedef struct {int id; bit lng;} ev_t;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] btn_n = 4'hF;
   logic [3:0] btn_level;
   logic       ev_overrun;
   ev_t        sb_q[$];
   int         n_chk = 0, n_pass = 0, ev_cnt = 0, ev_base;
   btn_event_arbiter_if #(.N_BTN(N_BTN)) ev_if ();
   btn_event_arbiter #(.N_BTN(N_BTN), .TICK_DIV(4), .DEB_TICKS(3), .LONG_TICKS(6)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_n      (btn_n),
      .btn_level  (btn_level),
      .ev         (ev_if.master),
      .ev_overrun (ev_overrun)
   );
   always #5 clk = ~clk;
   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask
   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic wait_level(int b, bit v, int max, string tag);
      for (int i = 0; i < max && btn_level[b] !== v; i++) cyc(1);
      chk(tag, btn_level[b], v);
   endtask
   task automatic wait_valid(int max, string tag);
      for (int i = 0; i < max && ev_if.valid !== 1'b1; i++) cyc(1);
      chk(tag, ev_if.valid, 1);
   endtask
   always @(negedge clk) begin
      if (rst_n && ev_if.valid && ev_if.ready) begin
         ev_t e;
         chk("ev_expected", sb_q.size() != 0, 1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("ev_id", ev_if.id, e.id);
            chk("ev_long", ev_if.long, e.lng);
         end
         ev_cnt++;
      end
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end
   initial begin
      bit lvl_seen;
      ev_if.ready = 1'b0;
      cyc(3);
      chk("rst_level", btn_level, 0);
      chk("rst_valid", ev_if.valid, 0);
      chk("rst_id", ev_if.id, 0);
      chk("rst_long", ev_if.long, 0);
      chk("rst_overrun", ev_overrun, 0);
      rst_n = 1'b1;
      cyc(2);
      // reset while an event is on offer
      btn_n = 4'hE;
      wait_valid(40, "t1_offer");
      rst_n = 1'b0;
      #1;
      chk("t1_valid", ev_if.valid, 0);
      chk("t1_id", ev_if.id, 0);
      chk("t1_long", ev_if.long, 0);
      chk("t1_level", btn_level, 0);
      chk("t1_overrun", ev_overrun, 0);
      btn_n = 4'hF;
      cyc(3);
      rst_n = 1'b1;
      cyc(40);
      chk("t1_quiet_valid", ev_if.valid, 0);
      chk("t1_quiet_level", btn_level, 0);
      // bounce: never three consecutive differing ticks
      ev_base = ev_cnt;
      lvl_seen = 1'b0;
      for (int p = 0; p < 3; p++) begin
         btn_n = p == 1 ? 4'hF : 4'hE;
         for (int i = 0; i < (p == 1 ? 4 : 8); i++) begin
            cyc(1);
            lvl_seen |= btn_level[0];
         end
      end
      btn_n = 4'hF;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         lvl_seen |= btn_level[0];
      end
      chk("t2_level_stayed_low", lvl_seen, 0);
      chk("t2_no_event", ev_cnt - ev_base, 0);
      chk("t2_valid", ev_if.valid, 0);
      // clean press with consumer ready
      ev_if.ready = 1'b1;
      ev_base = ev_cnt;
      sb_q.push_back('{0, 1'b0});
      btn_n = 4'hE;
      wait_level(0, 1'b1, 14, "t3_level_rise");
      btn_n = 4'hF;
      cyc(40);
      chk("t3_one_event", ev_cnt - ev_base, 1);
      chk("t3_level_fall", btn_level[0], 0);
      // simultaneous presses on 1 and 3, held off by ready=0
      ev_if.ready = 1'b0;
      sb_q.push_back('{1, 1'b0});
      sb_q.push_back('{3, 1'b0});
      btn_n = 4'b0101;
      wait_valid(30, "t4_offer");
      btn_n = 4'hF;
      chk("t4_id", ev_if.id, 1);
      chk("t4_long", ev_if.long, 0);
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         chk("t4_hold_valid", ev_if.valid, 1);
         chk("t4_hold_id", ev_if.id, 1);
      end
      ev_if.ready = 1'b1;
      cyc(1);
      ev_if.ready = 1'b0;
      chk("t4_gap", ev_if.valid, 0);
      cyc(1);
      chk("t4_next_valid", ev_if.valid, 1);
      chk("t4_next_id", ev_if.id, 3);
      ev_if.ready = 1'b1;
      cyc(20);
      // long hold on button 2
      ev_base = ev_cnt;
      sb_q.push_back('{2, 1'b0});
      sb_q.push_back('{2, 1'b1});
      btn_n = 4'hB;
      wait_level(2, 1'b1, 14, "t5_level_rise");
      cyc(60);
      chk("t5_events_while_held", ev_cnt - ev_base, 2);
      btn_n = 4'hF;
      cyc(40);
      chk("t5_events_total", ev_cnt - ev_base, 2);
      chk("t5_overrun_clear", ev_overrun, 0);
      // second press merges into the still-pending first one
      ev_if.ready = 1'b0;
      ev_base = ev_cnt;
      sb_q.push_back('{2, 1'b0});
      for (int p = 0; p < 2; p++) begin
         btn_n = 4'hB;
         wait_level(2, 1'b1, 14, "t6_rise");
         btn_n = 4'hF;
         wait_level(2, 1'b0, 14, "t6_fall");
      end
      chk("t6_overrun", ev_overrun, 1);
      chk("t6_offer_id", ev_if.id, 2);
      chk("t6_offer_valid", ev_if.valid, 1);
      cyc(10);
      chk("t6_overrun_sticky", ev_overrun, 1);
      ev_if.ready = 1'b1;
      cyc(30);
      chk("t6_one_event", ev_cnt - ev_base, 1);
      chk("t6_overrun_after", ev_overrun, 1);
      chk("sb_drained", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
